// File: rtl/sump_cmd_rx.sv
// SUMP command receiver: assembles 1-byte short and 5-byte long commands into registered strobes.
// Define LOGIP_OLS_EXT_EN to decode the OLS extension opcodes; otherwise those strobes stay 0.
module sump_cmd_rx #(
    parameter int NUM_STAGES  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        stb_i,
    input  logic [7:0]  byte_i,
    output logic        sft_rst_o,
    output logic        arm_o,
    output logic        id_o,
    output logic        xon_o,
    output logic        xoff_o,
    output logic        set_mask_o,
    output logic        set_val_o,
    output logic        set_cfg_o,
    output logic        set_div_o,
    output logic        set_cnt_o,
    output logic        set_flgs_o,
    output logic        rd_meta_o,
    output logic        fin_now_o,
    output logic        rd_inp_o,
    output logic        arm_adv_o,
    output logic        set_adv_cfg_o,
    output logic        set_adv_dat_o,
    output logic [1:0]  stg_o,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        err_unk_o,
    output logic        err_tmo_o
);
    localparam int TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam int S_SFT = 0,  S_ARM = 1,  S_ID = 2,   S_XON = 3,   S_XOFF = 4;
    localparam int S_MASK = 5, S_VAL = 6,  S_CFG = 7,  S_DIV = 8,   S_CNT = 9,  S_FLGS = 10;
    localparam int S_META = 11, S_FIN = 12, S_INP = 13, S_AADV = 14, S_ACFG = 15, S_ADAT = 16;
    localparam int S_UNK = 17, S_TMO = 18, NSTR = 19;

    typedef enum logic {IDLE, ARG} state_e;

    state_e            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       arg_q, arg_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        stg_q, stg_d;
    logic [NSTR-1:0]   str_q, str_d;

    // One-hot strobe vector for a completed command; anything unrecognised maps to S_UNK.
    function automatic logic [NSTR-1:0] decode(input logic [7:0] op);
        logic [NSTR-1:0] v;
        v = '0;
        case (op)
            8'h00: v[S_SFT]  = 1'b1;
            8'h01: v[S_ARM]  = 1'b1;
            8'h02: v[S_ID]   = 1'b1;
            8'h11: v[S_XON]  = 1'b1;
            8'h13: v[S_XOFF] = 1'b1;
            8'h80: v[S_DIV]  = 1'b1;
            8'h81: v[S_CNT]  = 1'b1;
            8'h82: v[S_FLGS] = 1'b1;
`ifdef LOGIP_OLS_EXT_EN
            8'h04: v[S_META] = 1'b1;
            8'h05: v[S_FIN]  = 1'b1;
            8'h06: v[S_INP]  = 1'b1;
            8'h0F: v[S_AADV] = 1'b1;
            8'h9E: v[S_ACFG] = 1'b1;
            8'h9F: v[S_ADAT] = 1'b1;
`endif
            default: begin
                if (op[7:4] == 4'hC && int'(op[3:2]) < NUM_STAGES) begin
                    case (op[1:0])
                        2'd0:    v[S_MASK] = 1'b1;
                        2'd1:    v[S_VAL]  = 1'b1;
                        2'd2:    v[S_CFG]  = 1'b1;
                        default: v[S_UNK]  = 1'b1;
                    endcase
                end else begin
                    v[S_UNK] = 1'b1;
                end
            end
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        arg_d   = arg_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        stg_d   = stg_q;
        str_d   = '0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (stb_i) begin
                    op_d = byte_i;
                    if (byte_i[7]) begin
                        cnt_d   = '0;
                        state_d = ARG;
                    end else begin
                        str_d = decode(byte_i);
                        stg_d = byte_i[3:2];
                    end
                end
            end
            ARG: begin
                if (stb_i) begin
                    tmo_d = '0;
                    if (cnt_q == 2'd3) begin
                        data_d  = {byte_i, arg_q};
                        str_d   = decode(op_q);
                        stg_d   = op_q[3:2];
                        state_d = IDLE;
                    end else begin
                        // LSB-first: shifting down leaves byte 1 in [7:0] after three bytes
                        arg_d = {byte_i, arg_q[23:8]};
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (TIMEOUT_CYC != 0) begin
                    if (tmo_q == TMO_LAST) begin
                        str_d[S_TMO] = 1'b1;
                        tmo_d        = '0;
                        state_d      = IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            arg_q   <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            stg_q   <= '0;
            str_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            arg_q   <= arg_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            stg_q   <= stg_d;
            str_q   <= str_d;
        end
    end

    assign sft_rst_o     = str_q[S_SFT];
    assign arm_o         = str_q[S_ARM];
    assign id_o          = str_q[S_ID];
    assign xon_o         = str_q[S_XON];
    assign xoff_o        = str_q[S_XOFF];
    assign set_mask_o    = str_q[S_MASK];
    assign set_val_o     = str_q[S_VAL];
    assign set_cfg_o     = str_q[S_CFG];
    assign set_div_o     = str_q[S_DIV];
    assign set_cnt_o     = str_q[S_CNT];
    assign set_flgs_o    = str_q[S_FLGS];
    assign rd_meta_o     = str_q[S_META];
    assign fin_now_o     = str_q[S_FIN];
    assign rd_inp_o      = str_q[S_INP];
    assign arm_adv_o     = str_q[S_AADV];
    assign set_adv_cfg_o = str_q[S_ACFG];
    assign set_adv_dat_o = str_q[S_ADAT];
    assign err_unk_o     = str_q[S_UNK];
    assign err_tmo_o     = str_q[S_TMO];
    assign stg_o         = stg_q;
    assign data_o        = data_q;
    assign busy_o        = (state_q == ARG);
endmodule
